// File: rtl/uart_report_arbiter.sv
// Round-robin, message-granular arbiter sharing one byte-serial UART transmitter
// between N_SRC report sources; revokes a grant when a source stalls past TIMEOUT.
module uart_report_arbiter #(
   parameter int N_SRC   = 2,
   parameter int TIMEOUT = 1023
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_SRC-1:0]     src_req,
   input  logic [8*N_SRC-1:0]   src_data,
   input  logic [N_SRC-1:0]     src_valid,
   input  logic [N_SRC-1:0]     src_last,
   output logic [N_SRC-1:0]     src_require,
   output logic [N_SRC-1:0]     grant,
   input  logic                 require,
   output logic [7:0]           data,
   output logic                 valid,
   output logic [15:0]          timeout_cnt
);

   localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [IW-1:0] LAST_IDX    = IW'(N_SRC - 1);
   localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_REQ,
      WAIT_BYTE,
      RELEASE
   } state_t;

   state_t            state, state_nxt;
   logic [IW-1:0]     gidx, gidx_nxt;
   logic [IW-1:0]     rr_ptr, rr_ptr_nxt;
   logic [N_SRC-1:0]  grant_nxt;
   logic [N_SRC-1:0]  src_require_nxt;
   logic              pending, pending_nxt;
   logic [TW-1:0]     timer, timer_nxt;
   logic [7:0]        data_nxt;
   logic              valid_nxt;
   logic [15:0]       timeout_cnt_nxt;

   logic [IW-1:0]     win_idx;
   logic              win_found;
   logic [7:0]        sel_byte;

   // First requester strictly after rr_ptr, wrapping back to rr_ptr itself last.
   always_comb begin
      int unsigned cand;
      cand      = 0;
      win_idx   = rr_ptr;
      win_found = 1'b0;
      for (int unsigned k = 1; k <= N_SRC; k++) begin
         cand = 32'(rr_ptr) + k;
         if (cand >= N_SRC) cand = cand - N_SRC;
         if (!win_found && src_req[IW'(cand)]) begin
            win_found = 1'b1;
            win_idx   = IW'(cand);
         end
      end
   end

   always_comb begin
      sel_byte = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (gidx == IW'(i)) sel_byte = src_data[8*i +: 8];
      end
   end

   always_comb begin
      state_nxt       = state;
      gidx_nxt        = gidx;
      rr_ptr_nxt      = rr_ptr;
      grant_nxt       = grant;
      src_require_nxt = '0;
      pending_nxt     = pending | require;
      timer_nxt       = timer;
      data_nxt        = data;
      valid_nxt       = 1'b0;
      timeout_cnt_nxt = timeout_cnt;

      unique case (state)
         IDLE: begin
            if (win_found) begin
               gidx_nxt  = win_idx;
               grant_nxt = N_SRC'(1) << win_idx;
               state_nxt = WAIT_REQ;
            end
         end
         WAIT_REQ: begin
            if (!src_req[gidx]) begin
               state_nxt = RELEASE;
            end else if (require || pending) begin
               src_require_nxt = grant;
               pending_nxt     = 1'b0;
               timer_nxt       = '0;
               state_nxt       = WAIT_BYTE;
            end
         end
         WAIT_BYTE: begin
            timer_nxt = timer + 1'b1;
            // A byte arriving on the deadline cycle still counts as on time.
            if (src_valid[gidx]) begin
               data_nxt  = sel_byte;
               valid_nxt = 1'b1;
               state_nxt = src_last[gidx] ? RELEASE : WAIT_REQ;
            end else if (timer == TIMEOUT_VAL) begin
               if (timeout_cnt != '1) timeout_cnt_nxt = timeout_cnt + 1'b1;
               state_nxt = RELEASE;
            end
         end
         RELEASE: begin
            rr_ptr_nxt = gidx;
            grant_nxt  = '0;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         gidx        <= '0;
         rr_ptr      <= LAST_IDX;
         grant       <= '0;
         src_require <= '0;
         pending     <= 1'b0;
         timer       <= '0;
         data        <= '0;
         valid       <= 1'b0;
         timeout_cnt <= '0;
      end else begin
         state       <= state_nxt;
         gidx        <= gidx_nxt;
         rr_ptr      <= rr_ptr_nxt;
         grant       <= grant_nxt;
         src_require <= src_require_nxt;
         pending     <= pending_nxt;
         timer       <= timer_nxt;
         data        <= data_nxt;
         valid       <= valid_nxt;
         timeout_cnt <= timeout_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_uart_report_arbiter.sv
// Self-checking bench for uart_report_arbiter: message table plus hand-written
// corner sequences, with a byte scoreboard checked against the UART-side strobe.
module tb_uart_report_arbiter;

   localparam int N_SRC    = 2;
   localparam int TIMEOUT  = 15;
   localparam int WAIT_LIM = 100;

   logic                clk = 1'b0;
   logic                rst;
   logic [N_SRC-1:0]    src_req;
   logic [8*N_SRC-1:0]  src_data;
   logic [N_SRC-1:0]    src_valid;
   logic [N_SRC-1:0]    src_last;
   logic [N_SRC-1:0]    src_require;
   logic [N_SRC-1:0]    grant;
   logic                require;
   logic [7:0]          data;
   logic                valid;
   logic [15:0]         timeout_cnt;

   uart_report_arbiter #(
      .N_SRC   (N_SRC),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .src_req     (src_req),
      .src_data    (src_data),
      .src_valid   (src_valid),
      .src_last    (src_last),
      .src_require (src_require),
      .grant       (grant),
      .require     (require),
      .data        (data),
      .valid       (valid),
      .timeout_cnt (timeout_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   bit req_auto   = 1'b0;
   bit prev_valid = 1'b0;

   typedef struct {
      logic [7:0] b;
      int         cyc_exp;
   } sb_t;
   sb_t sb[$];
   sb_t mon_e;

   typedef struct {
      logic [1:0]  req_mask;
      int unsigned src;
      int unsigned n;
      logic [31:0] bytes;
      logic [1:0]  after_mask;
      bit          noise;
   } msg_t;
   msg_t tbl[7];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Transmitter model: one require pulse every 20 cycles while enabled.
   initial begin
      require = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (req_auto) require = (cyc % 20 == 0);
      end
   end

   always @(negedge clk) begin
      check("grant_onehot", 32'(grant & (grant - 1'b1)), 32'd0);
      check("require_to_grant_only", 32'(src_require & ~grant), 32'd0);
      if (valid) begin
         check("valid_back_to_back", 32'(prev_valid), 32'd0);
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_valid: got data 0x%0h, expected no byte (cycle %0d)", data, cyc);
         end else begin
            mon_e = sb.pop_front();
            check("data", 32'(data), 32'(mon_e.b));
            check("valid_latency", 32'(cyc), 32'(mon_e.cyc_exp));
         end
      end
      prev_valid = valid;
   end

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; src_req = '0; src_valid = '0; src_last = '0; src_data = '0; require = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic pulse_require();
      @(posedge clk); #1; require = 1'b1;
      @(posedge clk); #1; require = 1'b0;
   endtask

   task automatic wait_grant(input int unsigned s, input string name);
      bit seen_zero;
      bit got;
      seen_zero = (grant == '0);
      got = 1'b0;
      for (int i = 0; i < WAIT_LIM; i++) begin
         @(negedge clk);
         if (grant != '0 && seen_zero) begin
            got = 1'b1;
            break;
         end
         if (grant == '0) seen_zero = 1'b1;
      end
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: grant wait expired, got 0x%0h, expected 0x%0h", name, grant, 32'(1) << s);
      end else begin
         check(name, 32'(grant), 32'(1) << s);
      end
   endtask

   task automatic wait_require(input int unsigned s, input string name);
      bit got;
      got = 1'b0;
      for (int i = 0; i < WAIT_LIM; i++) begin
         @(negedge clk);
         if (src_require[s]) begin
            got = 1'b1;
            break;
         end
      end
      check(name, 32'(got), 32'd1);
   endtask

   task automatic drive_byte(input int unsigned s, input logic [7:0] b, input bit last, input bit noise);
      sb_t e;
      @(posedge clk); #1;
      src_valid[s] = 1'b1;
      src_last[s]  = last;
      src_data[8*s +: 8] = b;
      if (noise) begin
         src_valid[1-s] = 1'b1;
         src_last[1-s]  = 1'b1;
         src_data[8*(1-s) +: 8] = 8'hEE;
      end
      e.b = b;
      e.cyc_exp = cyc + 1;
      sb.push_back(e);
      @(posedge clk); #1;
      src_valid = '0;
      src_last  = '0;
   endtask

   initial begin
      rst = 1'b1; src_req = '0; src_valid = '0; src_last = '0; src_data = '0;

      tbl[0] = '{2'b01, 0, 3, 32'h00434241, 2'b00, 1'b0};
      tbl[1] = '{2'b11, 1, 2, 32'h0000A1A0, 2'b11, 1'b1};
      tbl[2] = '{2'b11, 0, 2, 32'h0000B1B0, 2'b11, 1'b1};
      tbl[3] = '{2'b11, 1, 2, 32'h0000C1C0, 2'b11, 1'b0};
      tbl[4] = '{2'b11, 0, 2, 32'h0000D1D0, 2'b00, 1'b0};
      tbl[5] = '{2'b10, 1, 1, 32'h000000E5, 2'b00, 1'b0};
      tbl[6] = '{2'b10, 1, 4, 32'h13121110, 2'b00, 1'b0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_src_require", 32'(src_require), 32'd0);
      check("rst_data", 32'(data), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Message table: single source, round robin with contention, lone repeat winner.
      req_auto = 1'b1;
      for (int r = 0; r < 7; r++) begin
         src_req = tbl[r].req_mask;
         wait_grant(tbl[r].src, "rr_grant");
         for (int k = 0; k < int'(tbl[r].n); k++) begin
            wait_require(tbl[r].src, "msg_src_require");
            drive_byte(tbl[r].src, tbl[r].bytes[8*k +: 8], (k == int'(tbl[r].n) - 1), tbl[r].noise);
         end
         src_req = tbl[r].after_mask;
         @(posedge clk);
         @(negedge clk);
         check("grant_idle_gap", 32'(grant), 32'd0);
      end
      req_auto = 1'b0;
      require  = 1'b0;
      check("table_no_timeouts", 32'(timeout_cnt), 32'd0);

      // Require arriving while idle is remembered.
      do_reset();
      repeat (2) @(posedge clk);
      pulse_require();
      repeat (4) @(posedge clk);
      #1 src_req = 2'b10;
      wait_grant(1, "early_grant");
      check("early_no_pulse_yet", 32'(src_require), 32'd0);
      @(negedge clk);
      check("early_src_require", 32'(src_require), 32'b10);
      drive_byte(1, 8'h5A, 1'b1, 1'b0);
      src_req = '0;

      // Timeout on silent source 0, then source 1 is granted.
      do_reset();
      src_req = 2'b11;
      wait_grant(0, "to_first_grant");
      pulse_require();
      wait_require(0, "to_src_require");
      repeat (15) @(negedge clk);
      check("to_cnt_before", 32'(timeout_cnt), 32'd0);
      @(negedge clk);
      check("to_cnt_after", 32'(timeout_cnt), 32'd1);
      check("to_release_grant", 32'(grant), 32'b01);
      @(negedge clk);
      check("to_grant_cleared", 32'(grant), 32'd0);
      @(negedge clk);
      check("to_next_grant", 32'(grant), 32'b10);

      // Byte on the deadline cycle wins; dropped src_req during WAIT_BYTE is ignored.
      pulse_require();
      wait_require(1, "bw_src_require");
      src_req = 2'b01;
      repeat (14) @(posedge clk);
      drive_byte(1, 8'hC3, 1'b1, 1'b0);
      src_req = '0;
      @(negedge clk);
      check("bw_no_timeout", 32'(timeout_cnt), 32'd1);

      // Reset in the middle of a message.
      src_req = 2'b01;
      wait_grant(0, "mr_grant");
      pulse_require();
      wait_require(0, "mr_req1");
      drive_byte(0, 8'h61, 1'b0, 1'b0);
      pulse_require();
      wait_require(0, "mr_req2");
      @(posedge clk); #1;
      rst = 1'b1;
      src_req = 2'b11;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("mr_grant_cleared", 32'(grant), 32'd0);
      check("mr_valid", 32'(valid), 32'd0);
      check("mr_timeout_cnt", 32'(timeout_cnt), 32'd0);
      check("mr_src_require", 32'(src_require), 32'd0);
      @(negedge clk);
      check("mr_restart_src0", 32'(grant), 32'b01);
      src_req = '0;

      // Request drop in WAIT_REQ moves rr_ptr to the dropper.
      do_reset();
      src_req = 2'b01;
      wait_grant(0, "drop_grant");
      pulse_require();
      wait_require(0, "drop_req");
      drive_byte(0, 8'h77, 1'b0, 1'b0);
      src_req = 2'b10;
      @(posedge clk); #1;
      src_req = 2'b11;
      @(negedge clk);
      check("drop_release_grant", 32'(grant), 32'b01);
      @(negedge clk);
      check("drop_idle", 32'(grant), 32'd0);
      @(negedge clk);
      check("drop_prefers_src1", 32'(grant), 32'b10);
      src_req = '0;

      repeat (4) @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
